gray2bin_sync: RTL and testbench

//   Receive side of the gray-coded pointer crossing. It is the counterpart of the

---
 rtl/gray2bin_sync.sv | 88 ++++++++
 tb/tb_gray2bin_sync.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gray2bin_sync.sv
// Receive side of a gray-coded pointer crossing: synchronises a foreign-domain
// gray pointer, decodes it to binary and flags movement, wrap and illegal jumps.
module gray2bin_sync #(
   parameter int ADDRSIZE    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDRSIZE-1:0] gray_in,
   input  logic                err_clr,
   output logic [ADDRSIZE-1:0] bin_out,
   output logic                valid,
   output logic                changed,
   output logic                wrap,
   output logic                err_sticky
);

   localparam int FW = $clog2(SYNC_STAGES + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);

   logic [ADDRSIZE-1:0] sync [SYNC_STAGES];
   logic [ADDRSIZE-1:0] prev_gray;
   logic [FW-1:0]       fill;

   logic [ADDRSIZE-1:0] s_gray;
   logic [ADDRSIZE-1:0] s_bin;
   logic [ADDRSIZE-1:0] prev_bin;
   logic                multi_bit;

   function automatic logic [ADDRSIZE-1:0] gray2bin(input logic [ADDRSIZE-1:0] g);
      logic [ADDRSIZE-1:0] b;
      b[ADDRSIZE-1] = g[ADDRSIZE-1];
      for (int i = ADDRSIZE - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      s_gray    = sync[SYNC_STAGES-1];
      s_bin     = gray2bin(s_gray);
      prev_bin  = gray2bin(prev_gray);
      multi_bit = ($countones(s_gray ^ prev_gray) > 1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the synchroniser array is reset too; a stale pointer must not
         // survive a mid-operation reset.
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync[k] <= '0;
         end
         prev_gray  <= '0;
         fill       <= '0;
         bin_out    <= '0;
         valid      <= 1'b0;
         changed    <= 1'b0;
         wrap       <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         sync[0] <= gray_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync[k] <= sync[k-1];
         end
         prev_gray <= s_gray;
         bin_out   <= s_bin;

         if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
         end
         valid <= valid | (fill == FILL_MAX);

         // Checks are gated by the pre-edge valid so the reset-release fill
         // of a nonzero pointer never looks like movement or an illegal jump.
         changed <= valid && (s_gray != prev_gray);
         wrap    <= valid && (prev_bin == '1) && (s_bin == '0);

         if (valid && multi_bit) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gray2bin_sync.sv
// Directed bench for gray2bin_sync with ADDRSIZE=4, SYNC_STAGES=2: reset fill,
// full gray count, wrap, illegal jumps, err_clr priority and async reset.
module tb_gray2bin_sync;

   logic       clk;
   logic       rst_n;
   logic [3:0] gray_in;
   logic       err_clr;
   logic [3:0] bin_out;
   logic       valid;
   logic       changed;
   logic       wrap;
   logic       err_sticky;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] gray;
      logic [3:0] bin;
   } vec_t;

   vec_t tbl [16];

   gray2bin_sync #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray_in    (gray_in),
      .err_clr    (err_clr),
      .bin_out    (bin_out),
      .valid      (valid),
      .changed    (changed),
      .wrap       (wrap),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] b, input logic v,
                            input logic c, input logic w, input logic e);
      check({tag, ".bin"},     32'(bin_out),    32'(b));
      check({tag, ".valid"},   32'(valid),      32'(v));
      check({tag, ".changed"}, 32'(changed),    32'(c));
      check({tag, ".wrap"},    32'(wrap),       32'(w));
      check({tag, ".err"},     32'(err_sticky), 32'(e));
   endtask

   // Called at posedge+1; asserts reset mid-cycle, releases it before the next edge.
   task automatic do_reset(input logic [3:0] g);
      #2;
      rst_n   = 1'b0;
      gray_in = g;
      #1;
      check_all("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   // Refill after reset with gray_in held; b is its expected binary value.
   task automatic refill(input string tag, input logic [3:0] b);
      tick(); check_all({tag, ".e1"}, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); check_all({tag, ".e2"}, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); check_all({tag, ".e3"}, b,    1'b1, 1'b0, 1'b0, 1'b0);
      tick(); check_all({tag, ".e4"}, b,    1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{4'b0000, 4'd0};   tbl[1]  = '{4'b0001, 4'd1};
      tbl[2]  = '{4'b0011, 4'd2};   tbl[3]  = '{4'b0010, 4'd3};
      tbl[4]  = '{4'b0110, 4'd4};   tbl[5]  = '{4'b0111, 4'd5};
      tbl[6]  = '{4'b0101, 4'd6};   tbl[7]  = '{4'b0100, 4'd7};
      tbl[8]  = '{4'b1100, 4'd8};   tbl[9]  = '{4'b1101, 4'd9};
      tbl[10] = '{4'b1111, 4'd10};  tbl[11] = '{4'b1110, 4'd11};
      tbl[12] = '{4'b1010, 4'd12};  tbl[13] = '{4'b1011, 4'd13};
      tbl[14] = '{4'b1001, 4'd14};  tbl[15] = '{4'b1000, 4'd15};

      rst_n   = 1'b0;
      gray_in = 4'b0111;
      err_clr = 1'b0;
      #2;
      check_all("init", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;

      // 1) nonzero pointer held from reset release
      refill("s1", 4'd5);

      // 2) full gray count, one step per 4 cycles
      do_reset(4'b0000);
      refill("s2r", 4'd0);
      for (int i = 1; i < 16; i++) begin
         gray_in = tbl[i].gray;
         for (int k = 1; k <= 4; k++) begin
            tick();
            check_all($sformatf("s2.%0d.%0d", i, k),
                      (k >= 3) ? tbl[i].bin : tbl[i-1].bin,
                      1'b1, (k == 3), 1'b0, 1'b0);
         end
      end

      // 3) wrap 15 -> 0
      gray_in = 4'b0000;
      tick(); check_all("s3.e1", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); check_all("s3.e2", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); check_all("s3.e3", 4'd0,  1'b1, 1'b1, 1'b1, 1'b0);
      tick(); check_all("s3.e4", 4'd0,  1'b1, 1'b0, 1'b0, 1'b0);

      // 4) illegal two-bit jump 0000 -> 0011, then clear
      gray_in = 4'b0011;
      tick(); tick();
      tick(); check_all("s4.e3", 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(); check_all("s4.e4", 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      err_clr = 1'b1;
      tick(); check_all("s4.clr", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      err_clr = 1'b0;
      tick(); check_all("s4.hold", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);

      // 5) set and clear on the same edge: set wins
      gray_in = 4'b0101;
      tick(); tick();
      err_clr = 1'b1;
      tick(); check_all("s5.e3", 4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
      err_clr = 1'b0;
      tick(); check_all("s5.e4", 4'd6, 1'b1, 1'b0, 1'b0, 1'b1);
      err_clr = 1'b1;
      tick(); check("s5.clr", 32'(err_sticky), 32'd0);
      err_clr = 1'b0;

      // 6) async reset mid-count, then refill with 0111
      gray_in = 4'b0100;
      tick(); tick();
      #2;
      rst_n   = 1'b0;
      gray_in = 4'b0111;
      #1;
      check_all("s6.rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #4;
      rst_n = 1'b1;
      refill("s6", 4'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
